// File: rtl/round_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | round_sequencer: round clear/wait/play/flash controller with prescaler,  |
// | Galois LFSR random wait and registered LED controls.                     |
// | Optional macro: ROUND_SEQ_FALSE_START_EN (winrnd in WAIT restarts round) |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module round_sequencer #(
    parameter int unsigned       DIV_W       = 8,
    parameter int unsigned       LFSR_W      = 8,
    parameter logic [LFSR_W-1:0] TAPS        = 8'hB8,
    parameter int unsigned       RAND_BITS   = 4,
    parameter int unsigned       MIN_WAIT    = 4,
    parameter int unsigned       FLASH_TICKS = 8,
    parameter int unsigned       AUTO        = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       winrnd,
    input  logic       start,
    output logic       leds_on,
    output logic       clear,
    output logic [1:0] led_control
`ifdef ROUND_SEQ_FALSE_START_EN
    ,
    output logic       false_start
`endif
);

    localparam int unsigned c_wait_max = MIN_WAIT + (2 ** RAND_BITS);
    localparam int unsigned c_cnt_max  = (c_wait_max > FLASH_TICKS) ? c_wait_max : FLASH_TICKS;
    localparam int unsigned c_cnt_w    = $clog2(c_cnt_max + 1);

    localparam logic [c_cnt_w-1:0] c_min_wait = c_cnt_w'(MIN_WAIT);
    localparam logic [c_cnt_w-1:0] c_flash    = c_cnt_w'(FLASH_TICKS);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [LFSR_W-1:0]  c_seed     = LFSR_W'(1);

    localparam logic [1:0] c_ctl_normal = 2'b00;
    localparam logic [1:0] c_ctl_all_on = 2'b01;
    localparam logic [1:0] c_ctl_off    = 2'b10;
    localparam logic [1:0] c_ctl_flash  = 2'b11;

    localparam logic [2:0] c_st_clr  = 3'd0;
    localparam logic [2:0] c_st_wait = 3'd1;
    localparam logic [2:0] c_st_go   = 3'd2;
    localparam logic [2:0] c_st_win  = 3'd3;
    localparam logic [2:0] c_st_hold = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_next;
    logic [DIV_W-1:0]   r_div;
    logic               w_tick;
    logic [LFSR_W-1:0]  r_lfsr;
    logic [LFSR_W-1:0]  w_lfsr_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_inc;
    logic [c_cnt_w-1:0] r_wait_len;
    logic               w_wait_done;
    logic               w_flash_done;
    logic               w_leds_on;
    logic               w_clear;
    logic [1:0]         w_led_control;

    assign w_tick       = &r_div;
    assign w_cnt_inc    = r_cnt + c_cnt_one;
    assign w_wait_done  = w_tick && (w_cnt_inc == r_wait_len);
    assign w_flash_done = w_tick && (w_cnt_inc == c_flash);

    // Galois step; the all-zero lock-up state is forced back to the seed.
    always_comb begin
        w_lfsr_next = {1'b0, r_lfsr[LFSR_W-1:1]} ^ (r_lfsr[0] ? TAPS : '0);
        if (r_lfsr == '0) begin
            w_lfsr_next = c_seed;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div      <= '0;
            r_lfsr     <= c_seed;
            r_cnt      <= '0;
            r_wait_len <= '0;
        end else begin
            r_div  <= r_div + DIV_W'(1);
            r_lfsr <= w_lfsr_next;
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (w_tick) begin
                r_cnt <= w_cnt_inc;
            end
            if (r_state == c_st_clr) begin
                r_wait_len <= c_min_wait + {{(c_cnt_w - RAND_BITS){1'b0}}, r_lfsr[RAND_BITS-1:0]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_st_clr;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_clr:  w_next = c_st_wait;
            c_st_wait: begin
`ifdef ROUND_SEQ_FALSE_START_EN
                if (winrnd) begin
                    w_next = c_st_clr;
                end else if (w_wait_done) begin
                    w_next = c_st_go;
                end
`else
                if (w_wait_done) begin
                    w_next = c_st_go;
                end
`endif
            end
            c_st_go: begin
                if (winrnd) begin
                    w_next = c_st_win;
                end
            end
            c_st_win: begin
                if (w_flash_done) begin
                    w_next = (AUTO != 0) ? c_st_clr : c_st_hold;
                end
            end
            c_st_hold: begin
                if (start) begin
                    w_next = c_st_clr;
                end
            end
            default:   w_next = c_st_clr;
        endcase
    end

    always_comb begin
        w_leds_on     = 1'b0;
        w_clear       = 1'b0;
        w_led_control = c_ctl_off;
        case (r_state)
            c_st_clr:  w_clear = 1'b1;
            c_st_go: begin
                w_leds_on     = 1'b1;
                w_led_control = c_ctl_normal;
            end
            c_st_win: begin
                w_leds_on     = 1'b1;
                w_led_control = c_ctl_flash;
            end
            c_st_hold: begin
                w_leds_on     = 1'b1;
                w_led_control = c_ctl_all_on;
            end
            default: begin
                w_leds_on     = 1'b0;
                w_led_control = c_ctl_off;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            leds_on     <= 1'b0;
            clear       <= 1'b0;
            led_control <= c_ctl_off;
        end else begin
            leds_on     <= w_leds_on;
            clear       <= w_clear;
            led_control <= w_led_control;
        end
    end

`ifdef ROUND_SEQ_FALSE_START_EN
    // Remembers that the pending CLR was entered from WAIT, so the flag lines up with clear.
    logic r_fs_pending;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fs_pending <= 1'b0;
            false_start  <= 1'b0;
        end else begin
            r_fs_pending <= (r_state == c_st_wait) && winrnd;
            false_start  <= (r_state == c_st_clr) && r_fs_pending;
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/round_sequencer.md
Name: round_sequencer

Overview:
- Parametrised successor to the tug-of-war clear/LED round controller: prescaler, LFSR and master control FSM in one block.
- Clears the playfield and holds LEDs dark for a pseudo-random number of slow ticks, then enables play.
- On a won round, flashes the LEDs and either restarts automatically or waits for a start request.
- Sits between the player-input/score logic (source of winrnd) and the LED driver (consumer of leds_on, clear, led_control).

Parameters:
- DIV_W, 8, prescaler width; slow tick every 2^DIV_W clk cycles.
- LFSR_W, 8, LFSR width; must be 3..16.
- TAPS, 8'hB8, LFSR feedback tap mask, Galois form, LFSR_W bits.
- RAND_BITS, 4, LFSR low bits used as the random wait addend.
- MIN_WAIT, 4, minimum wait in slow ticks; must be >= 1.
- FLASH_TICKS, 8, length of the win flash in slow ticks; must be >= 1.
- AUTO, 1, 1 = restart after the flash; 0 = hold until start.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- winrnd  input  1  round won, level-sampled in GO only.
- start  input  1  restart request, sampled in HOLD only (AUTO=0).
- leds_on  output  1  playfield LEDs enabled.
- clear  output  1  one-cycle clear pulse to score/position logic.
- led_control  output  2  00 normal, 01 all-on, 10 all-off, 11 flash.

Behaviour:
- All outputs registered. Each output changes 1 clk after the condition that causes it.
- Reset (rst=0), asynchronous and immediate, including mid-round:
  - state = CLR, leds_on = 0, clear = 0, led_control = 10;
  - prescaler = 0, LFSR = 1, tick counter = 0.
- Prescaler:
  - free-running DIV_W-bit up-counter that wraps;
  - tick = 1 for one clk when the counter is all-ones.
- LFSR:
  - advances every clk; never enters all-zero;
  - if all-zero is detected, force the next value to 1.
- Tick counter:
  - width CNT_W = clog2(max(MIN_WAIT + 2^RAND_BITS, FLASH_TICKS) + 1);
  - cleared on every state entry.
- State CLR:
  - clear = 1 for exactly one clk; leds_on = 0; led_control = 10;
  - latch wait_len = MIN_WAIT + lfsr[RAND_BITS-1:0] (zero-extended to CNT_W); go to WAIT next cycle.
- State WAIT:
  - leds_on = 0; led_control = 10; winrnd ignored;
  - count ticks; on the tick that makes the count equal wait_len, go to GO.
- State GO:
  - leds_on = 1; led_control = 00;
  - winrnd = 1 on any clk goes to WIN; a tick in the same cycle is irrelevant.
- State WIN:
  - leds_on = 1; led_control = 11;
  - after FLASH_TICKS ticks, go to CLR if AUTO=1, else to HOLD.
- State HOLD (AUTO=0 only):
  - leds_on = 1; led_control = 01;
  - start = 1 goes to CLR.
- start outside HOLD is ignored. winrnd outside GO is ignored.
- winrnd held high across a restart re-triggers WIN only once GO is reached again.
- Wait range is MIN_WAIT .. MIN_WAIT + 2^RAND_BITS - 1 ticks. The first tick after state entry may arrive 1 .. 2^DIV_W clk later (partial period).
- clear is never high in two consecutive cycles.
- Unused state encodings go to CLR.

Optional Feature:
- Macro: ROUND_SEQ_FALSE_START_EN.
- Defined:
  - winrnd = 1 during WAIT is a false start: go to CLR (fresh clear pulse, new random wait_len);
  - adds output false_start (1 bit), a one-clk pulse in the cycle CLR is entered this way.
- Not defined:
  - winrnd is ignored in WAIT;
  - the false_start port does not exist.

Test Plan:
- Reset release, DIV_W=2, LFSR seed 1, RAND_BITS=4, MIN_WAIT=4 -> clear high exactly 1 clk after rst rises; led_control=10; wait_len=5; leds_on rises after the 5th tick; led_control=00.
- GO, winrnd pulsed 1 clk -> next clk led_control=11; after 8 ticks clear pulses again (AUTO=1); leds_on=0 during the following WAIT.
- AUTO=0, win completes -> led_control=01 held for 100 clk with start=0; start=1 -> clear pulse next clk.
- rst asserted mid-WIN -> same cycle: leds_on=0, clear=0, led_control=10; normal sequence restarts on release.
- Run 300 rounds -> every wait_len in 4..19; LFSR never zero; clear never high two cycles running.
- With ROUND_SEQ_FALSE_START_EN, winrnd=1 in WAIT -> false_start and clear pulse together 1 clk later; new wait_len latched; without the macro, WAIT completes unchanged.
